// File: rtl/nla_pkg.sv
// nla_pkg: constants and types shared by the input and output sides of the
// nonlinear approximation engine stream.
package nla_pkg;
    localparam int          NLA_RAM_WIDTH  = 32;
    localparam int          NLA_ADDR_LINES = 5;
    localparam logic [31:0] NLA_START_WORD = 32'h7F90_0000;
    typedef enum logic [1:0] {IDLE, START, DATA} tx_state_t;
endpackage

// File: rtl/frame_fifo_mem.sv
// frame_fifo_mem: register-array buffer, synchronous write, asynchronous read.
module frame_fifo_mem #(
    parameter int WIDTH      = 33,
    parameter int ADDR_LINES = 5
) (
    input  logic                  clk_i,
    input  logic                  we,
    input  logic [ADDR_LINES-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [ADDR_LINES-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);
    logic [WIDTH-1:0] mem [2**ADDR_LINES];
    always_ff @(posedge clk_i) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/output_frame_tx.sv
// output_frame_tx: buffers result words and streams complete frames, each
// prefixed with the start token, on a valid/ready interface.
module output_frame_tx
    import nla_pkg::*;
#(
    parameter int                   RAM_WIDTH  = NLA_RAM_WIDTH,
    parameter int                   ADDR_LINES = NLA_ADDR_LINES,
    parameter logic [RAM_WIDTH-1:0] START_WORD = RAM_WIDTH'(NLA_START_WORD)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en,
    input  logic [RAM_WIDTH-1:0] data_i,
    input  logic                 last_i,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 drop_o,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i,
    output logic [RAM_WIDTH-1:0] tx_data_o,
    output logic                 tx_start_o,
    output logic                 tx_last_o
);
    localparam int            PW   = ADDR_LINES + 1;
    localparam logic [PW-1:0] HALF = PW'(1) << ADDR_LINES;

    tx_state_t            state, next_state;
    logic [PW-1:0]        wr_ptr, rd_ptr, frame_cnt;
    logic                 accept, hs, pop, load_start, go_idle, head_last;
    logic [RAM_WIDTH-1:0] head_data;

    assign full_o  = (wr_ptr ^ rd_ptr) == HALF;
    assign empty_o = wr_ptr == rd_ptr;
    assign accept  = wr_en && !full_o && data_i != START_WORD;
    assign hs      = tx_valid_o && tx_ready_i;

    frame_fifo_mem #(.WIDTH(RAM_WIDTH + 1), .ADDR_LINES(ADDR_LINES)) u_mem (
        .clk_i (clk_i),
        .we    (accept),
        .waddr (wr_ptr[ADDR_LINES-1:0]),
        .wdata ({last_i, data_i}),
        .raddr (rd_ptr[ADDR_LINES-1:0]),
        .rdata ({head_last, head_data})
    );

    // frame_cnt only counts complete frames, so DATA never sees an empty buffer
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        load_start = 1'b0;
        go_idle    = 1'b0;
        case (state)
            IDLE: if (frame_cnt != '0) begin
                next_state = START;
                load_start = 1'b1;
            end
            START: if (hs) begin
                next_state = DATA;
                pop        = 1'b1;
            end
            DATA: if (hs) begin
                if (!tx_last_o) begin
                    pop = 1'b1;
                end else if (frame_cnt != '0) begin
                    next_state = START;
                    load_start = 1'b1;
                end else begin
                    next_state = IDLE;
                    go_idle    = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            frame_cnt  <= '0;
            drop_o     <= 1'b0;
            tx_valid_o <= 1'b0;
            tx_data_o  <= '0;
            tx_start_o <= 1'b0;
            tx_last_o  <= 1'b0;
        end else begin
            state     <= next_state;
            drop_o    <= wr_en && !accept;
            wr_ptr    <= wr_ptr + PW'(accept);
            rd_ptr    <= rd_ptr + PW'(pop);
            frame_cnt <= frame_cnt + PW'(accept && last_i) - PW'(pop && head_last);
            if (load_start) begin
                tx_valid_o <= 1'b1;
                tx_data_o  <= START_WORD;
                tx_start_o <= 1'b1;
                tx_last_o  <= 1'b0;
            end else if (pop) begin
                tx_valid_o <= 1'b1;
                tx_data_o  <= head_data;
                tx_start_o <= 1'b0;
                tx_last_o  <= head_last;
            end else if (go_idle) begin
                tx_valid_o <= 1'b0;
                tx_start_o <= 1'b0;
                tx_last_o  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_output_frame_tx.sv
// tb_output_frame_tx: random-stimulus bench against a frame-level queue model.
module tb_output_frame_tx;
    localparam logic [31:0] SW = 32'h7F90_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0, wr_en = 1'b0, last_i = 1'b0, tx_ready_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        full_o, empty_o, drop_o, tx_valid_o, tx_start_o, tx_last_o;
    logic [31:0] tx_data_o;

    int          checks = 0, errors = 0, mdl_cnt = 0;
    logic [33:0] exp_q[$], rx_q[$];
    logic [31:0] part[$];

    always #5 clk_i = ~clk_i;

    output_frame_tx dut (
        .clk_i(clk_i), .rst_i(rst_i), .wr_en(wr_en), .data_i(data_i), .last_i(last_i),
        .full_o(full_o), .empty_o(empty_o), .drop_o(drop_o), .tx_valid_o(tx_valid_o),
        .tx_ready_i(tx_ready_i), .tx_data_o(tx_data_o), .tx_start_o(tx_start_o),
        .tx_last_o(tx_last_o)
    );

    // every word accepted by the stream, sampled mid-cycle
    always @(negedge clk_i) begin
        if (!rst_i && tx_valid_o && tx_ready_i) begin
            rx_q.push_back({tx_start_o, tx_last_o, tx_data_o});
            if (!tx_start_o) mdl_cnt--;
        end
    end

    // a closed frame appears on the stream as START token followed by its words
    function automatic void model_write(logic [31:0] d, logic l);
        if (mdl_cnt >= 32 || d == SW) return;
        mdl_cnt++;
        part.push_back(d);
        if (l) begin
            exp_q.push_back({2'b10, SW});
            foreach (part[i]) exp_q.push_back({1'b0, i == part.size() - 1, part[i]});
            part.delete();
        end
    endfunction

    function automatic logic [31:0] rnd();
        logic [31:0] w = $urandom;
        return (w == SW) ? w ^ 32'h1 : w;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [31:0] d, input logic l);
        wr_en = 1'b1; data_i = d; last_i = l;
        model_write(d, l);
        tick();
        wr_en = 1'b0; last_i = 1'b0;
    endtask

    task automatic reset_dut();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        part.delete(); exp_q.delete(); rx_q.delete(); mdl_cnt = 0;
    endtask

    task automatic wait_done(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < n && !ok; c++) begin
            if (rx_q.size() == exp_q.size() && !tx_valid_o) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if ({tx_valid_o, tx_start_o, tx_last_o, drop_o, empty_o, full_o} !== 6'b000010) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000010", {tx_valid_o, tx_start_o, tx_last_o, drop_o, empty_o, full_o});
        end
        checks++;
        if (tx_data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 00000000", tx_data_o);
        end
    endtask

    task automatic test_single_frame();
        logic [34:0] want [5];
        logic [34:0] got;
        bit ok;
        want = '{35'h0, {3'b110, SW}, {3'b100, 32'h3F80_0000}, {3'b101, 32'h4000_0000}, 35'h0};
        tx_ready_i = 1'b1;
        wr(32'h3F80_0000, 1'b0);
        wr(32'h4000_0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            got = {tx_valid_o, tx_start_o, tx_last_o, tx_data_o};
            checks++;
            if (want[i][34] ? got !== want[i] : got[34] !== 1'b0) begin
                errors++;
                $display("FAIL single_cycle%0d: got %h want %h", i, got, want[i]);
            end
            tick();
        end
        wait_done(20, ok);
        checks++;
        if (!ok || rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL single_len: got %0d words want %0d", rx_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < rx_q.size()) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL single_word%0d: got %h want %h", i, rx_q[i], exp_q[i]);
            end
        end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [34:0] prev;
        logic        stall;
        bit          done, ok;
        tx_ready_i = 1'b0;
        wr(32'h3F80_0000, 1'b0);
        wr(32'h4000_0000, 1'b1);
        for (int i = 0; i < 5; i++) wr(rnd(), i == 4);
        done = 1'b0;
        for (int c = 0; c < 120 && !done; c++) begin
            tx_ready_i = (c % 4 == 0) || (c % 4 == 3);
            prev  = {tx_valid_o, tx_start_o, tx_last_o, tx_data_o};
            stall = tx_valid_o && !tx_ready_i;
            tick();
            if (stall) begin
                checks++;
                if ({tx_valid_o, tx_start_o, tx_last_o, tx_data_o} !== prev) begin
                    errors++;
                    $display("FAIL bp_hold: got %h want %h", {tx_valid_o, tx_start_o, tx_last_o, tx_data_o}, prev);
                end
            end
            done = rx_q.size() == exp_q.size() && !tx_valid_o;
        end
        tx_ready_i = 1'b1;
        wait_done(20, ok);
        checks++;
        if (!ok || rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bp_len: got %0d words want %0d", rx_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < rx_q.size()) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_word%0d: got %h want %h", i, rx_q[i], exp_q[i]);
            end
        end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int         run;
        logic [7:0] starts;
        bit         ok;
        tx_ready_i = 1'b0;
        for (int f = 0; f < 2; f++) for (int i = 0; i < 3; i++) wr(rnd(), i == 2);
        tx_ready_i = 1'b1;
        for (int c = 0; c < 5 && !tx_valid_o; c++) tick();
        run = 0; starts = '0;
        while (tx_valid_o && run < 20) begin
            if (tx_start_o && run < 8) starts[run] = 1'b1;
            run++;
            tick();
        end
        checks++;
        if (run != 8) begin
            errors++;
            $display("FAIL b2b_run: got %0d valid cycles want 8", run);
        end
        checks++;
        if (starts !== 8'b0001_0001) begin
            errors++;
            $display("FAIL b2b_starts: got %b want 00010001", starts);
        end
        wait_done(20, ok);
        checks++;
        if (!ok || rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_len: got %0d words want %0d", rx_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < rx_q.size()) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_word%0d: got %h want %h", i, rx_q[i], exp_q[i]);
            end
        end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_incomplete();
        bit ok;
        tx_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) wr(rnd(), 1'b0);
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (tx_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL incomplete_idle%0d: got valid %b want 0", c, tx_valid_o);
            end
            tick();
        end
        wr(rnd(), 1'b1);
        checks++;
        if (tx_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL incomplete_latency0: got valid %b want 0", tx_valid_o);
        end
        tick();
        checks++;
        if ({tx_valid_o, tx_start_o, tx_data_o} !== {2'b11, SW}) begin
            errors++;
            $display("FAIL incomplete_start: got %h want %h", {tx_valid_o, tx_start_o, tx_data_o}, {2'b11, SW});
        end
        wait_done(30, ok);
        checks++;
        if (!ok || rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL incomplete_len: got %0d words want %0d", rx_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < rx_q.size()) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL incomplete_word%0d: got %h want %h", i, rx_q[i], exp_q[i]);
            end
        end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_full_drop();
        reset_dut();
        tx_ready_i = 1'b0;
        for (int i = 0; i < 32; i++) wr(rnd(), 1'b0);
        checks++;
        if ({full_o, empty_o, drop_o} !== 3'b100) begin
            errors++;
            $display("FAIL full_after32: got full/empty/drop %b want 100", {full_o, empty_o, drop_o});
        end
        wr(rnd(), 1'b1);
        checks++;
        if ({full_o, empty_o, drop_o} !== 3'b101) begin
            errors++;
            $display("FAIL full_drop33: got full/empty/drop %b want 101", {full_o, empty_o, drop_o});
        end
        tick();
        checks++;
        if ({drop_o, tx_valid_o} !== 2'b00) begin
            errors++;
            $display("FAIL full_pulse: got drop/valid %b want 00", {drop_o, tx_valid_o});
        end
        checks++;
        if (mdl_cnt != 32) begin
            errors++;
            $display("FAIL full_model: got %0d stored want 32", mdl_cnt);
        end
        reset_dut();
    endtask

    task automatic test_start_drop();
        bit ok;
        tx_ready_i = 1'b1;
        wr(SW, 1'b1);
        checks++;
        if ({drop_o, empty_o} !== 2'b11) begin
            errors++;
            $display("FAIL token_drop: got drop/empty %b want 11", {drop_o, empty_o});
        end
        repeat (3) tick();
        checks++;
        if ({drop_o, tx_valid_o, empty_o} !== 3'b001) begin
            errors++;
            $display("FAIL token_noframe: got drop/valid/empty %b want 001", {drop_o, tx_valid_o, empty_o});
        end
        wr(rnd(), 1'b1);
        wait_done(20, ok);
        checks++;
        if (!ok || rx_q.size() != 2 || exp_q.size() != 2) begin
            errors++;
            $display("FAIL token_len: got %0d words want 2", rx_q.size());
        end
        foreach (exp_q[i]) if (i < rx_q.size()) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL token_word%0d: got %h want %h", i, rx_q[i], exp_q[i]);
            end
        end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        tx_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) wr(rnd(), i == 3);
        for (int c = 0; c < 20 && rx_q.size() < 3; c++) tick();
        checks++;
        if (rx_q.size() != 3) begin
            errors++;
            $display("FAIL mid_progress: got %0d words want 3", rx_q.size());
        end
        rst_i = 1'b1;
        tick();
        checks++;
        if ({tx_valid_o, tx_start_o, tx_last_o, drop_o, empty_o, full_o, tx_data_o} !== {6'b000010, 32'h0}) begin
            errors++;
            $display("FAIL mid_reset: got %h want %h", {tx_valid_o, tx_start_o, tx_last_o, drop_o, empty_o, full_o, tx_data_o}, {6'b000010, 32'h0});
        end
        rst_i = 1'b0;
        part.delete(); exp_q.delete(); rx_q.delete(); mdl_cnt = 0;
        for (int i = 0; i < 3; i++) wr(rnd(), i == 2);
        wait_done(20, ok);
        checks++;
        if (!ok || rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL mid_len: got %0d words want %0d", rx_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < rx_q.size()) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL mid_word%0d: got %h want %h", i, rx_q[i], exp_q[i]);
            end
        end
        rx_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_back_to_back();
        test_incomplete();
        test_full_drop();
        test_start_drop();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule

// File: doc/output_frame_tx.md
# output_frame_tx

Output-side counterpart of the engine's input FIFO. Buffers 32-bit float results from the nonlinear approximation datapath and transmits them as framed words on a valid/ready stream. Each frame is prefixed with the reserved NaN start token 0x7F900000, the same token the input side uses to mark frame start. A frame is transmitted only once it is completely buffered, so a frame on the stream is never stalled by an underflow.

## Interface
Parameters:
- RAM_WIDTH, 32: data word width.
- ADDR_LINES, 5: log2 of buffer depth; depth = 32 words.
- START_WORD, 32'h7F90_0000: start token, emitted ahead of every frame and never stored.

Ports:
- clk_i, input, 1: the single clock.
- rst_i, input, 1: reset, synchronous, active-high.
- wr_en, input, 1: write a result word.
- data_i, input, RAM_WIDTH: result word.
- last_i, input, 1: qualifies data_i as the final word of a frame.
- full_o, output, 1: buffer holds 2^ADDR_LINES words.
- empty_o, output, 1: buffer holds 0 words.
- drop_o, output, 1: one-cycle pulse when a write is discarded.
- tx_valid_o, output, 1: tx_data_o is valid.
- tx_ready_i, input, 1: downstream accepts the word.
- tx_data_o, output, RAM_WIDTH: transmitted word.
- tx_start_o, output, 1: high while tx_data_o is START_WORD.
- tx_last_o, output, 1: high while tx_data_o is the last word of a frame.

## Operation
Storage:
- Circular buffer of {last, data} entries, RAM_WIDTH+1 bits wide.
- wr_ptr and rd_ptr are ADDR_LINES+1 bits; the MSB disambiguates full from empty.
- full_o = (wr_ptr ^ rd_ptr) == {1'b1, 0...0}.
- empty_o = (wr_ptr == rd_ptr).

Writes:
- A write is accepted when wr_en && !full_o && data_i != START_WORD.
- A write is dropped, with drop_o pulsed the next cycle, when wr_en && (full_o || data_i == START_WORD).
- A dropped last_i does not close a frame.

frame_cnt (ADDR_LINES+1 bits):
- Increments on an accepted write with last_i set.
- Decrements when an entry with last set is popped.
- A simultaneous increment and decrement leaves it unchanged.

Pop and handshake:
- Handshake: tx_valid_o && tx_ready_i.
- Pop: the head entry is loaded into the output register and rd_ptr increments.
- While tx_valid_o && !tx_ready_i, tx_data_o, tx_start_o and tx_last_o hold stable.

FSM states IDLE, START, DATA:
- IDLE: tx_valid_o=0. If frame_cnt != 0, go to START and load START_WORD with tx_start_o=1.
- START: on handshake, pop the head into the output register and go to DATA.
- DATA, on handshake with tx_last_o=0: pop the next entry and stay in DATA.
- DATA, on handshake with tx_last_o=1: go to START and load START_WORD if frame_cnt != 0 (back-to-back frames); otherwise go to IDLE with tx_valid_o=0.
- DATA never encounters an empty buffer, because frame_cnt guarantees the frame is complete.
- A zero-length frame cannot exist: every frame carries at least one data word, which is its last.

Reset values:
- Pointers, frame_cnt: 0.
- State: IDLE.
- tx_valid_o, tx_start_o, tx_last_o, drop_o: 0.
- tx_data_o: 0.
- empty_o=1, full_o=0.
- A reset mid-frame discards all buffered data and the partial transmission. The stream restarts cleanly with START_WORD for the next complete frame.

## Timing
- Writes take effect on the clock edge; full_o and empty_o update the cycle after.
- Frame latency: the last word is written at edge E; frame_cnt=1 after E; START_WORD is valid after E+1.
- Each word is valid the cycle after the preceding handshake edge. The stream sustains 1 word per clock while tx_ready_i=1.
- Back-to-back frames: the START_WORD of frame n+1 follows the last word of frame n with no idle cycle.
- A word written in the same cycle as a pop is stored normally.
- When the buffer is full, a pop in the same cycle as a write does not free space for that write; the write is dropped.

## Structure
- Shared package nla_pkg holds START_WORD (shared with the input side), the state enum {IDLE, START, DATA}, and the default RAM_WIDTH and ADDR_LINES.
- One sub-module, frame_fifo_mem: a register-array buffer with a synchronous write port and an asynchronous read port on {last, data}.
- Pointer logic, frame_cnt, the FSM and the output register live in the top module.

## Test plan
- Single frame: write 0x3F800000, 0x40000000 (last) with tx_ready_i=1. Expect 0x7F900000 (tx_start_o) after E+1, then 0x3F800000, then 0x40000000 (tx_last_o), then tx_valid_o=0.
- Backpressure: same frame with tx_ready_i toggling 1,0,0,1 per cycle. Expect tx_data_o stable through stalls, no word lost or duplicated, identical word order.
- Back-to-back frames: buffer two 3-word frames, hold ready=1. Expect 8 consecutive valid cycles (2 START_WORD + 6 data), with tx_start_o at positions 0 and 4.
- Incomplete frame: write 5 words without last_i. Expect tx_valid_o=0 throughout. A 6th word with last_i starts transmission after 2 cycles.
- Full/drop: write 33 words with ready=0. Expect full_o after the 32nd write, a drop_o pulse for the 33rd, and empty_o=0. Writing data_i=0x7F900000 gives a drop_o pulse and the pointer unchanged.
- Reset mid-frame: assert rst_i after 2 of 4 words have transmitted. Expect all outputs at reset values the next cycle and empty_o=1. A new frame afterwards begins with START_WORD.
